// File: rtl/dram_port_arbiter_if.sv
// Bundles the two requester ports and the dram_controller user port shared by the arbiter.
interface dram_port_arbiter_if #(
  parameter int unsigned ADDRW = 26,
  parameter int unsigned DATAW = 128
);
  logic             r0_read;
  logic             r0_write;
  logic [ADDRW-1:0] r0_address;
  logic [DATAW-1:0] r0_write_data;
  logic [DATAW-1:0] r0_read_data;
  logic             r0_ack;
  logic             r0_busy;

  logic             r1_read;
  logic             r1_write;
  logic [ADDRW-1:0] r1_address;
  logic [DATAW-1:0] r1_write_data;
  logic [DATAW-1:0] r1_read_data;
  logic             r1_ack;
  logic             r1_busy;

  logic             m_read;
  logic             m_write;
  logic [ADDRW-1:0] m_address;
  logic [DATAW-1:0] m_write_data;
  logic [DATAW-1:0] m_read_data;
  logic             m_ack;
  logic             m_busy;

  // Arbiter-side view
  modport slave (
    input  r0_read, r0_write, r0_address, r0_write_data,
    output r0_read_data, r0_ack, r0_busy,
    input  r1_read, r1_write, r1_address, r1_write_data,
    output r1_read_data, r1_ack, r1_busy,
    output m_read, m_write, m_address, m_write_data,
    input  m_read_data, m_ack, m_busy
  );

  // Environment-side view (requesters plus controller)
  modport master (
    output r0_read, r0_write, r0_address, r0_write_data,
    input  r0_read_data, r0_ack, r0_busy,
    output r1_read, r1_write, r1_address, r1_write_data,
    input  r1_read_data, r1_ack, r1_busy,
    input  m_read, m_write, m_address, m_write_data,
    output m_read_data, m_ack, m_busy
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one dram_controller user port between two requesters,
// one transaction at a time, with a sticky watchdog for a controller that never acks.
module dram_port_arbiter #(
  parameter int unsigned ADDRW   = 26,
  parameter int unsigned DATAW   = 128,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  dram_port_arbiter_if.slave  bus,
  output logic [1:0]          o_grant,
  output logic                o_timeout
);

  localparam int unsigned WDW = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RELEASE} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic             wr_q, wr_d;
  logic             rel_q, rel_d;
  logic             ack_prev_q;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [DATAW-1:0] wdata_q, wdata_d;
  logic [DATAW-1:0] rdata0_q, rdata0_d;
  logic [DATAW-1:0] rdata1_q, rdata1_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic             m_read_q, m_read_d;
  logic             m_write_q, m_write_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       ack_q, ack_d;

  logic [1:0]       req;
  logic             winner;
  logic             ack_rise;

  assign req      = {bus.r1_read | bus.r1_write, bus.r0_read | bus.r0_write};
  // On a tie the requester that did not win last time gets the port
  assign winner   = (&req) ? ~last_q : req[1];
  assign ack_rise = bus.m_ack & ~ack_prev_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    rel_d     = rel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    wdog_d    = wdog_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    timeout_d = timeout_q;
    grant_d   = grant_q;
    ack_d     = 2'b00;

    unique case (state_q)
      IDLE: begin
        rel_d = 1'b0;
        if (!bus.m_busy && !timeout_q && (|req)) begin
          last_d  = winner;
          owner_d = winner;
          grant_d = winner ? 2'b10 : 2'b01;
          wr_d    = winner ? bus.r1_write : bus.r0_write;
          addr_d  = winner ? bus.r1_address : bus.r0_address;
          wdata_d = winner ? bus.r1_write_data : bus.r0_write_data;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        wdog_d    = '0;
        m_write_d = wr_q;
        m_read_d  = ~wr_q;
        state_d   = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (ack_rise) begin
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          if (!wr_q) begin
            if (owner_q) rdata1_d = bus.m_read_data;
            else         rdata0_d = bus.m_read_data;
          end
          ack_d   = owner_q ? 2'b10 : 2'b01;
          state_d = RELEASE;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          timeout_d = 1'b1;
          grant_d   = 2'b00;
          state_d   = IDLE;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end

      RELEASE: begin
        // Owner gets one cycle to drop its level request after the ack
        rel_d = 1'b1;
        if (!bus.m_ack && (!req[owner_q] || rel_q)) begin
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = bus.m_busy | timeout_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      rel_q      <= 1'b0;
      ack_prev_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      wdog_q     <= '0;
      m_read_q   <= 1'b0;
      m_write_q  <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b1;
      grant_q    <= 2'b00;
      ack_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      rel_q      <= rel_d;
      ack_prev_q <= bus.m_ack;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      wdog_q     <= wdog_d;
      m_read_q   <= m_read_d;
      m_write_q  <= m_write_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.m_read       = m_read_q;
  assign bus.m_write      = m_write_q;
  assign bus.m_address    = addr_q;
  assign bus.m_write_data = wdata_q;
  assign bus.r0_read_data = rdata0_q;
  assign bus.r1_read_data = rdata1_q;
  assign bus.r0_ack       = ack_q[0];
  assign bus.r1_ack       = ack_q[1];
  assign bus.r0_busy      = busy_q;
  assign bus.r1_busy      = busy_q;
  assign o_grant          = grant_q;
  assign o_timeout        = timeout_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: vector table for arbitration/data paths,
// hand sequences for busy, latency, watchdog and mid-transaction reset.
module tb_dram_port_arbiter;

  localparam int unsigned ADDRW   = 26;
  localparam int unsigned DATAW   = 128;
  localparam int unsigned TIMEOUT = 16;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_RW   = 2'b11;

  localparam logic [DATAW-1:0] ZERO = '0;
  localparam logic [DATAW-1:0] A5   = {16{8'hA5}};
  localparam logic [DATAW-1:0] D10  = {16{8'h10}};
  localparam logic [DATAW-1:0] D20  = {16{8'h20}};
  localparam logic [DATAW-1:0] W3   = {4{32'hDEAD_BEEF}};
  localparam logic [DATAW-1:0] W4   = {4{32'h0BAD_F00D}};
  localparam logic [DATAW-1:0] W5   = {4{32'h1234_5678}};

  typedef struct {
    int               n0;
    logic [1:0]       op0;
    logic [ADDRW-1:0] a0;
    logic [DATAW-1:0] w0;
    int               n1;
    logic [1:0]       op1;
    logic [ADDRW-1:0] a1;
    logic [DATAW-1:0] w1;
    int               dly;
    int               hold;
    int               ncmd;
    logic [3:0]       order;
    logic             first_wr;
    logic [ADDRW-1:0] first_addr;
    logic [DATAW-1:0] rd0;
    logic [DATAW-1:0] rd1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant;
  logic       timeout;

  dram_port_arbiter_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  dram_port_arbiter #(.ADDRW(ADDRW), .DATAW(DATAW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .bus      (bus),
    .o_grant  (grant),
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  // Stimulus controls written by the main sequence
  int               tgt0 = 0, tgt1 = 0;
  logic [1:0]       op0 = OP_NONE, op1 = OP_NONE;
  logic [ADDRW-1:0] addr0 = '0, addr1 = '0;
  logic [DATAW-1:0] wdata0 = '0, wdata1 = '0;
  int               ack_delay = 1, ack_hold = 0;
  logic             never_ack = 1'b0;

  // State owned by the negedge requester/controller models
  int               acks0 = 0, acks1 = 0;
  int               mdl_cnt = 0, mdl_hold = 0;
  int               proto_err = 0;
  int               log_n = 0;
  logic             log_wr [32];
  logic             log_own [32];
  logic [ADDRW-1:0] log_addr [32];
  logic [DATAW-1:0] mem [bit [ADDRW-1:0]];

  int n_cmp = 0;
  int n_bad = 0;

  // Requesters hold a level request until acked; controller acks after ack_delay cycles
  always @(negedge clk) begin
    logic req0, req1;
    if (bus.m_read && bus.m_write) proto_err++;
    if (bus.m_ack && (bus.m_read || bus.m_write)) proto_err++;

    if (bus.r0_ack) acks0++;
    if (bus.r1_ack) acks1++;
    req0 = (acks0 < tgt0) && !bus.r0_ack;
    req1 = (acks1 < tgt1) && !bus.r1_ack;
    bus.r0_read       = req0 && op0[0];
    bus.r0_write      = req0 && op0[1];
    bus.r0_address    = addr0;
    bus.r0_write_data = wdata0;
    bus.r1_read       = req1 && op1[0];
    bus.r1_write      = req1 && op1[1];
    bus.r1_address    = addr1;
    bus.r1_write_data = wdata1;

    if (!rst_n) begin
      bus.m_ack = 1'b0;
      mdl_cnt   = 0;
      mdl_hold  = 0;
    end else if (bus.m_ack) begin
      if (mdl_hold == 0) bus.m_ack = 1'b0;
      else               mdl_hold--;
    end else if ((bus.m_read || bus.m_write) && !never_ack) begin
      if (mdl_cnt >= ack_delay) begin
        if (log_n < 32) begin
          log_wr[log_n]   = bus.m_write;
          log_own[log_n]  = grant[1];
          log_addr[log_n] = bus.m_address;
        end
        log_n++;
        if (bus.m_write) mem[bus.m_address] = bus.m_write_data;
        else bus.m_read_data = mem.exists(bus.m_address) ? mem[bus.m_address] : ZERO;
        bus.m_ack = 1'b1;
        mdl_hold  = ack_hold;
        mdl_cnt   = 0;
      end else begin
        mdl_cnt++;
      end
    end else begin
      mdl_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k = 0;
    while (!(acks0 >= tgt0 && acks1 >= tgt1 && grant == 2'b00) && k < limit) begin
      tick();
      k++;
    end
    check(name, DATAW'(k < limit), DATAW'(1));
  endtask

  vec_t vecs [5];

  initial begin
    int a0s, a1s, base, bad;
    logic [3:0] ord;
    logic seen;

    bus.m_busy      = 1'b1;
    bus.m_ack       = 1'b0;
    bus.m_read_data = '0;
    mem[26'h10] = D10;
    mem[26'h20] = D20;

    //           n0 op0    a0           w0    n1 op1    a1           w1    dly hold ncmd order    fwr   faddr        rd0  rd1
    vecs[0] = '{0, OP_NONE, 26'h0,      ZERO, 1, OP_RW, 26'h3FFFFFF, W3,   1,  0,   1,   4'b0001, 1'b1, 26'h3FFFFFF, A5,  ZERO};
    vecs[1] = '{2, OP_RD,   26'h10,     ZERO, 2, OP_RD, 26'h20,      ZERO, 1,  0,   4,   4'b1010, 1'b0, 26'h10,      D10, D20};
    vecs[2] = '{1, OP_RD,   26'h3FFFFFF, ZERO, 1, OP_WR, 26'h10,     W4,   2,  2,   2,   4'b0010, 1'b0, 26'h3FFFFFF, W3,  D20};
    vecs[3] = '{0, OP_NONE, 26'h0,      ZERO, 1, OP_RD, 26'h10,      ZERO, 5,  0,   1,   4'b0001, 1'b0, 26'h10,      W3,  W4};
    vecs[4] = '{1, OP_WR,   26'h20,     W5,   1, OP_RD, 26'h20,      ZERO, 0,  1,   2,   4'b0010, 1'b1, 26'h20,      W3,  W5};

    // Reset with controller still initialising
    repeat (3) tick();
    check("rst m_read",  DATAW'(bus.m_read), DATAW'(0));
    check("rst m_write", DATAW'(bus.m_write), DATAW'(0));
    check("rst grant",   DATAW'(grant), DATAW'(0));
    check("rst timeout", DATAW'(timeout), DATAW'(0));
    check("rst r0_busy", DATAW'(bus.r0_busy), DATAW'(1));
    check("rst r1_busy", DATAW'(bus.r1_busy), DATAW'(1));
    check("rst r0_ack",  DATAW'(bus.r0_ack), DATAW'(0));
    rst_n = 1'b1;
    op0 = OP_RD; addr0 = 26'h10; tgt0 = acks0 + 1;
    bad = 0;
    repeat (100) begin
      tick();
      if (bus.m_read || bus.m_write || !bus.r0_busy || !bus.r1_busy || grant != 2'b00) bad++;
    end
    check("busy hold-off", DATAW'(bad), DATAW'(0));
    tgt0 = acks0;
    tick();
    bus.m_busy = 1'b0;
    tick();
    check("busy release r0", DATAW'(bus.r0_busy), DATAW'(0));
    check("busy release r1", DATAW'(bus.r1_busy), DATAW'(0));

    // r0 write then read back, with latency and grant checks
    ack_delay = 2;
    a0s = acks0;
    op0 = OP_WR; addr0 = 26'h123; wdata0 = A5; tgt0 = acks0 + 1;
    tick();
    check("wr grant",    DATAW'(grant), DATAW'(2'b01));
    check("wr early cmd", DATAW'(bus.m_write), DATAW'(0));
    tick();
    check("wr m_write",  DATAW'(bus.m_write), DATAW'(1));
    check("wr m_read",   DATAW'(bus.m_read), DATAW'(0));
    check("wr m_addr",   DATAW'(bus.m_address), DATAW'(26'h123));
    check("wr m_wdata",  bus.m_write_data, A5);
    wait_idle("wr done", 60);
    check("wr acks", DATAW'(acks0 - a0s), DATAW'(1));
    check("wr rdata unchanged", bus.r0_read_data, ZERO);
    op0 = OP_RD; tgt0 = acks0 + 1;
    tick();
    check("rd grant", DATAW'(grant), DATAW'(2'b01));
    tick();
    check("rd m_read", DATAW'(bus.m_read), DATAW'(1));
    wait_idle("rd done", 60);
    check("rd acks", DATAW'(acks0 - a0s), DATAW'(2));
    check("rd data", bus.r0_read_data, A5);

    // Table of arbitration vectors
    for (int i = 0; i < 5; i++) begin
      ack_delay = vecs[i].dly;
      ack_hold  = vecs[i].hold;
      base = log_n;
      a0s  = acks0;
      a1s  = acks1;
      op0 = vecs[i].op0; addr0 = vecs[i].a0; wdata0 = vecs[i].w0;
      op1 = vecs[i].op1; addr1 = vecs[i].a1; wdata1 = vecs[i].w1;
      tgt0 = acks0 + vecs[i].n0;
      tgt1 = acks1 + vecs[i].n1;
      wait_idle($sformatf("v%0d done", i), 400);
      ord = '0;
      for (int j = 0; j < 4; j++)
        if (j < log_n - base && base + j < 32) ord[j] = log_own[base + j];
      check($sformatf("v%0d ncmd", i), DATAW'(log_n - base), DATAW'(vecs[i].ncmd));
      check($sformatf("v%0d order", i), DATAW'(ord), DATAW'(vecs[i].order));
      check($sformatf("v%0d first op", i), DATAW'(log_wr[base]), DATAW'(vecs[i].first_wr));
      check($sformatf("v%0d first addr", i), DATAW'(log_addr[base]), DATAW'(vecs[i].first_addr));
      check($sformatf("v%0d r0 data", i), bus.r0_read_data, vecs[i].rd0);
      check($sformatf("v%0d r1 data", i), bus.r1_read_data, vecs[i].rd1);
      check($sformatf("v%0d r0 acks", i), DATAW'(acks0 - a0s), DATAW'(vecs[i].n0));
      check($sformatf("v%0d r1 acks", i), DATAW'(acks1 - a1s), DATAW'(vecs[i].n1));
    end

    // Watchdog: controller never acks
    never_ack = 1'b1;
    ack_hold  = 0;
    a0s = acks0;
    op0 = OP_WR; addr0 = 26'h55; wdata0 = W5; tgt0 = acks0 + 1;
    bad = 0; seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (bus.m_write) begin bad++; seen = 1'b1; end
      else if (seen) break;
    end
    check("to write cycles", DATAW'(bad), DATAW'(TIMEOUT));
    check("to flag",    DATAW'(timeout), DATAW'(1));
    check("to grant",   DATAW'(grant), DATAW'(0));
    check("to r0_busy", DATAW'(bus.r0_busy), DATAW'(1));
    check("to r1_busy", DATAW'(bus.r1_busy), DATAW'(1));
    check("to no ack",  DATAW'(acks0 - a0s), DATAW'(0));
    tgt0 = acks0;
    never_ack = 1'b0;
    op1 = OP_RD; addr1 = 26'h10; tgt1 = acks1 + 1;
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.m_read || bus.m_write || !bus.r1_busy || !timeout) bad++;
    end
    check("to locked", DATAW'(bad), DATAW'(0));
    tgt1 = acks1;
    rst_n = 1'b0;
    repeat (2) tick();
    check("to cleared by reset", DATAW'(timeout), DATAW'(0));
    rst_n = 1'b1;
    repeat (2) tick();
    check("post-reset busy", DATAW'(bus.r0_busy), DATAW'(0));

    // Reset in the middle of a read
    ack_delay = 12;
    a0s = acks0;
    op0 = OP_RD; addr0 = 26'h10; tgt0 = acks0 + 1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      seen = bus.m_read;
    end
    check("mid m_read seen", DATAW'(seen), DATAW'(1));
    repeat (2) tick();
    rst_n = 1'b0;
    tgt0 = acks0;
    tick();
    check("mid m_read drop", DATAW'(bus.m_read), DATAW'(0));
    check("mid grant drop",  DATAW'(grant), DATAW'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (bus.m_read || bus.m_write || bus.r0_ack) bad++;
    end
    check("mid no activity", DATAW'(bad), DATAW'(0));
    check("mid no ack", DATAW'(acks0 - a0s), DATAW'(0));

    check("protocol", DATAW'(proto_err), DATAW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
